ahb_lite_slave_mux: RTL and testbench



---
 rtl/ahb_lite_slave_mux_pkg.sv | 28 ++
 rtl/ahb_lite_slave_mux_default_slave.sv | 79 +++++++
 rtl/ahb_lite_slave_mux.sv | 85 ++++++++
 tb/tb_ahb_lite_slave_mux.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_slave_mux_pkg.sv
// Shared AHB-Lite definitions for the slave response mux and its default slave.
// Covers the HTRANS/HRESP encodings and the default-slave state type.
package ahb_lite_slave_mux_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OK   = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  // Only NONSEQ/SEQ carry a real transfer; IDLE/BUSY always get a zero-wait OKAY.
  function automatic logic is_active(input logic [1:0] htrans);
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_slave_mux_default_slave.sv
// Default slave: two-cycle ERROR response for unmapped transfers, plus a log of
// the last unmapped address and a saturating count of unmapped transfers.
module ahb_default_slave
  import ahb_lite_slave_mux_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hready,
  input  logic                 unmapped,
  input  logic [31:0]          haddr,
  output logic                 ds_hready,
  output logic                 ds_hresp,
  output logic [31:0]          err_addr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  ds_state_t            state_reg, state_next;
  logic [31:0]          err_addr_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;
  logic                 log_err;

  // An unmapped transfer only counts on an edge where the bus accepts the address phase.
  assign log_err = hready && unmapped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= DS_OK;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DS_OK:   if (log_err) state_next = DS_ERR1;
      DS_ERR1: state_next = DS_ERR2;
      DS_ERR2: state_next = log_err ? DS_ERR1 : DS_OK;
      default: state_next = DS_OK;
    endcase
  end

  always_comb begin
    ds_hready = 1'b1;
    ds_hresp  = HRESP_OKAY;
    case (state_reg)
      DS_ERR1: begin
        ds_hready = 1'b0;
        ds_hresp  = HRESP_ERROR;
      end
      DS_ERR2: begin
        ds_hready = 1'b1;
        ds_hresp  = HRESP_ERROR;
      end
      default: begin
        ds_hready = 1'b1;
        ds_hresp  = HRESP_OKAY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr_reg <= '0;
      err_cnt_reg  <= '0;
    end else if (log_err) begin
      err_addr_reg <= haddr;
      if (err_cnt_reg != '1) begin
        err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
      end
    end
  end

  assign err_addr = err_addr_reg;
  assign err_cnt  = err_cnt_reg;

endmodule

// File: rtl/ahb_lite_slave_mux.sv
// AHB-Lite data-phase response mux: registers the decoder select in the address
// phase and returns the chosen slave's response, or the default slave's on a miss.
module ahb_lite_slave_mux
  import ahb_lite_slave_mux_pkg::*;
#(
  parameter int DEVICES_EXP  = 4,
  parameter int DEVICES_USED = 11,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [31:0]                   HADDR,
  input  logic [1:0]                    HTRANS,
  input  logic [2**DEVICES_EXP-1:0]     HSEL_A,
  input  logic [DEVICES_EXP-1:0]        HSEL_ENCODE,
  input  logic [32*2**DEVICES_EXP-1:0]  HRDATA_S,
  input  logic [2**DEVICES_EXP-1:0]     HREADYOUT_S,
  input  logic [2**DEVICES_EXP-1:0]     HRESP_S,
  output logic [31:0]                   HRDATA,
  output logic                          HREADY,
  output logic                          HRESP,
  output logic [31:0]                   ERR_ADDR,
  output logic [ERR_CNT_W-1:0]          ERR_CNT
);

  localparam int NUM_SLOTS = 2**DEVICES_EXP;
  localparam logic [DEVICES_EXP:0] USED_LIMIT = (DEVICES_EXP+1)'(DEVICES_USED);

  logic [31:0]            slot_rdata [NUM_SLOTS];
  logic [DEVICES_EXP-1:0] data_sel_reg;
  logic                   data_hit_reg;
  logic                   addr_hit;
  logic                   unmapped;
  logic                   ds_hready;
  logic                   ds_hresp;
  logic                   unused_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign slot_rdata[gi] = HRDATA_S[32*gi +: 32];
    end
  endgenerate

  // An all-zero HSEL_A encodes as slot 0, so the one-hot OR is what rejects it.
  assign addr_hit   = (|HSEL_A[DEVICES_USED-1:0]) && ({1'b0, HSEL_ENCODE} < USED_LIMIT);
  assign unmapped   = is_active(HTRANS) && !addr_hit;
  assign unused_sel = &{1'b0, HSEL_A};

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      data_sel_reg <= '0;
      data_hit_reg <= 1'b0;
    end else if (HREADY) begin
      data_sel_reg <= HSEL_ENCODE;
      data_hit_reg <= addr_hit;
    end
  end

  always_comb begin
    HRDATA = '0;
    HREADY = ds_hready;
    HRESP  = ds_hresp;
    if (data_hit_reg) begin
      HRDATA = slot_rdata[data_sel_reg];
      HREADY = HREADYOUT_S[data_sel_reg];
      HRESP  = HRESP_S[data_sel_reg];
    end
  end

  ahb_default_slave #(
    .ERR_CNT_W(ERR_CNT_W)
  ) u_default_slave (
    .clk      (HCLK),
    .rst      (HRESET),
    .hready   (HREADY),
    .unmapped (unmapped),
    .haddr    (HADDR),
    .ds_hready(ds_hready),
    .ds_hresp (ds_hresp),
    .err_addr (ERR_ADDR),
    .err_cnt  (ERR_CNT)
  );

endmodule

// File: tb/tb_ahb_lite_slave_mux.sv
// Bench for ahb_lite_slave_mux: directed vector table, hand-written corner
// sequences, then randomized traffic against a transfer-level reference model.
module tb_ahb_lite_slave_mux;

  localparam int NS = 16;

  logic             HCLK = 1'b0;
  logic             HRESET;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic [NS-1:0]    HSEL_A;
  logic [3:0]       HSEL_ENCODE;
  logic [32*NS-1:0] HRDATA_S;
  logic [NS-1:0]    HREADYOUT_S;
  logic [NS-1:0]    HRESP_S;
  logic [31:0]      HRDATA;
  logic             HREADY;
  logic             HRESP;
  logic [31:0]      ERR_ADDR;
  logic [7:0]       ERR_CNT;

  logic [31:0] slot_rd [NS];

  int checks = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  always_comb begin
    HRDATA_S = '0;
    for (int n = 0; n < NS; n++) HRDATA_S[32*n +: 32] = slot_rd[n];
  end

  ahb_lite_slave_mux #(
    .DEVICES_EXP (4),
    .DEVICES_USED(11),
    .ERR_CNT_W   (8)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HSEL_A     (HSEL_A),
    .HSEL_ENCODE(HSEL_ENCODE),
    .HRDATA_S   (HRDATA_S),
    .HREADYOUT_S(HREADYOUT_S),
    .HRESP_S    (HRESP_S),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .ERR_ADDR   (ERR_ADDR),
    .ERR_CNT    (ERR_CNT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [1:0] trans,
                       input logic [NS-1:0] sel_a, input logic [3:0] enc);
    HADDR       = addr;
    HTRANS      = trans;
    HSEL_A      = sel_a;
    HSEL_ENCODE = enc;
  endtask

  typedef struct {
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic [NS-1:0] sel_a;
    logic [3:0]    enc;
    logic [NS-1:0] ro;
    logic [31:0]   e_rdata;
    logic          e_ready;
    logic          e_resp;
    logic [7:0]    e_cnt;
    logic [31:0]   e_addr;
  } vec_t;

  vec_t vecs[19];

  // Reference model state, described per transfer rather than per register.
  bit          m_hit;
  int          m_sel;
  int          m_err_left;  // error-response cycles still owed to the master (2, 1 or 0)
  int          m_cnt;
  logic [31:0] m_addr;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] e_rd, last_addr;
    logic        e_ry, e_rs, hit_c;
    int          mode, slot, waited;
    bit          got_ready;

    // Rows: inputs presented this cycle and the response expected in this same cycle.
    vecs[0]  = '{32'h0000_0000, 2'b00, 16'h0000, 4'd0,  16'hFFFF, 32'h0,         1'b1, 1'b0, 8'd0, 32'h0};
    vecs[1]  = '{32'h2000_0010, 2'b10, 16'h0002, 4'd1,  16'hFFFF, 32'h0,         1'b1, 1'b0, 8'd0, 32'h0};
    vecs[2]  = '{32'h0000_0000, 2'b00, 16'h0000, 4'd0,  16'hFFFF, 32'hDEAD_BEEF, 1'b1, 1'b0, 8'd0, 32'h0};
    vecs[3]  = '{32'h3000_0000, 2'b10, 16'h0008, 4'd3,  16'hFFFF, 32'h0,         1'b1, 1'b0, 8'd0, 32'h0};
    vecs[4]  = '{32'h0000_0004, 2'b10, 16'h0001, 4'd0,  16'hFFF7, 32'h5100_0003, 1'b0, 1'b0, 8'd0, 32'h0};
    vecs[5]  = '{32'h0000_0004, 2'b10, 16'h0001, 4'd0,  16'hFFF7, 32'h5100_0003, 1'b0, 1'b0, 8'd0, 32'h0};
    vecs[6]  = '{32'h0000_0004, 2'b10, 16'h0001, 4'd0,  16'hFFFF, 32'h5100_0003, 1'b1, 1'b0, 8'd0, 32'h0};
    vecs[7]  = '{32'h0000_0000, 2'b00, 16'h0000, 4'd0,  16'hFFFF, 32'h5100_0000, 1'b1, 1'b0, 8'd0, 32'h0};
    vecs[8]  = '{32'h8000_0000, 2'b10, 16'h0000, 4'd0,  16'hFFFF, 32'h0,         1'b1, 1'b0, 8'd0, 32'h0};
    vecs[9]  = '{32'h0000_0000, 2'b00, 16'h0000, 4'd0,  16'hFFFF, 32'h0,         1'b0, 1'b1, 8'd1, 32'h8000_0000};
    vecs[10] = '{32'h0000_0004, 2'b10, 16'h0001, 4'd0,  16'hFFFF, 32'h0,         1'b1, 1'b1, 8'd1, 32'h8000_0000};
    vecs[11] = '{32'h9000_0000, 2'b10, 16'h1000, 4'd12, 16'hFFFF, 32'h5100_0000, 1'b1, 1'b0, 8'd1, 32'h8000_0000};
    vecs[12] = '{32'h0000_0000, 2'b00, 16'h0000, 4'd0,  16'hFFFF, 32'h0,         1'b0, 1'b1, 8'd2, 32'h9000_0000};
    vecs[13] = '{32'h8000_0000, 2'b00, 16'h0000, 4'd0,  16'hFFFF, 32'h0,         1'b1, 1'b1, 8'd2, 32'h9000_0000};
    vecs[14] = '{32'hA000_0000, 2'b01, 16'h0000, 4'd0,  16'hFFFF, 32'h0,         1'b1, 1'b0, 8'd2, 32'h9000_0000};
    vecs[15] = '{32'h0000_0100, 2'b10, 16'h0001, 4'd11, 16'hFFFF, 32'h0,         1'b1, 1'b0, 8'd2, 32'h9000_0000};
    vecs[16] = '{32'h0000_0000, 2'b00, 16'h0000, 4'd0,  16'hFFFF, 32'h0,         1'b0, 1'b1, 8'd3, 32'h0000_0100};
    vecs[17] = '{32'h0000_0000, 2'b00, 16'h0000, 4'd0,  16'hFFFF, 32'h0,         1'b1, 1'b1, 8'd3, 32'h0000_0100};
    vecs[18] = '{32'h0000_0000, 2'b00, 16'h0000, 4'd0,  16'hFFFF, 32'h0,         1'b1, 1'b0, 8'd3, 32'h0000_0100};

    for (int n = 0; n < NS; n++) slot_rd[n] = 32'h5100_0000 | 32'(n);
    slot_rd[1] = 32'hDEAD_BEEF;
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    drive(32'h0, 2'b00, '0, 4'd0);
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 19; i++) begin
      @(posedge HCLK);
      #1;
      drive(vecs[i].haddr, vecs[i].htrans, vecs[i].sel_a, vecs[i].enc);
      HREADYOUT_S = vecs[i].ro;
      @(negedge HCLK);
      chk($sformatf("vec%0d_hrdata", i), HRDATA, vecs[i].e_rdata);
      chk($sformatf("vec%0d_hready", i), 32'(HREADY), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_hresp", i), 32'(HRESP), 32'(vecs[i].e_resp));
      chk($sformatf("vec%0d_err_cnt", i), 32'(ERR_CNT), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_err_addr", i), ERR_ADDR, vecs[i].e_addr);
      $display("vec %0d: htrans=%0d enc=%0d hrdata=%08h hready=%0b hresp=%0b err_cnt=%0d",
               i, vecs[i].htrans, vecs[i].enc, HRDATA, HREADY, HRESP, ERR_CNT);
    end

    // 300 back-to-back unmapped NONSEQs: counter must saturate at 255.
    last_addr = 32'h0;
    for (int i = 0; i < 300; i++) begin
      @(posedge HCLK);
      #1;
      last_addr = {2'b11, 30'($urandom)};
      drive(last_addr, 2'b10, '0, 4'd0);
      got_ready = 1'b0;
      waited = 0;
      while (!got_ready && waited < 4) begin
        @(negedge HCLK);
        got_ready = HREADY;
        waited++;
      end
      if (!got_ready) chk("sat_wait_hready", 32'(HREADY), 32'd1);
    end
    @(posedge HCLK);
    #1 drive(32'h0, 2'b00, '0, 4'd0);
    @(negedge HCLK);
    chk("sat_err_cnt", 32'(ERR_CNT), 32'd255);
    chk("sat_err_addr", ERR_ADDR, last_addr);
    $display("saturation: err_cnt=%0d err_addr=%08h", ERR_CNT, ERR_ADDR);
    repeat (3) @(posedge HCLK);

    // Asynchronous reset in the middle of an error response.
    #1 drive(32'hB000_0000, 2'b10, '0, 4'd0);
    @(posedge HCLK);
    #1 drive(32'h0, 2'b00, '0, 4'd0);
    #2;
    chk("pre_reset_hready", 32'(HREADY), 32'd0);
    chk("pre_reset_hresp", 32'(HRESP), 32'd1);
    HRESET = 1'b1;
    #1;
    chk("async_rst_hready", 32'(HREADY), 32'd1);
    chk("async_rst_hresp", 32'(HRESP), 32'd0);
    chk("async_rst_hrdata", HRDATA, 32'h0);
    chk("async_rst_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("async_rst_err_addr", ERR_ADDR, 32'h0);
    $display("async reset: hready=%0b hresp=%0b err_cnt=%0d", HREADY, HRESP, ERR_CNT);
    @(posedge HCLK);
    #1 HRESET = 1'b0;

    // Randomized traffic against the reference model.
    m_hit = 1'b0; m_sel = 0; m_err_left = 0; m_cnt = 0; m_addr = 32'h0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge HCLK);
      #1;
      mode = $urandom_range(0, 9);
      if (mode <= 5) begin
        slot = $urandom_range(0, 10);
        drive($urandom, 2'($urandom), NS'(1) << slot, 4'(slot));
      end else if (mode <= 7) begin
        slot = $urandom_range(11, 15);
        drive($urandom, 2'($urandom), NS'(1) << slot, 4'(slot));
      end else if (mode == 8) begin
        drive($urandom, 2'($urandom), '0, 4'd0);
      end else begin
        drive($urandom, 2'($urandom), NS'(1) << $urandom_range(0, 15), 4'($urandom));
      end
      for (int n = 0; n < NS; n++) begin
        slot_rd[n]     = $urandom;
        HREADYOUT_S[n] = ($urandom_range(0, 3) != 0);
        HRESP_S[n]     = ($urandom_range(0, 9) == 0);
      end
      @(negedge HCLK);

      if (m_hit) begin
        e_rd = slot_rd[m_sel]; e_ry = HREADYOUT_S[m_sel]; e_rs = HRESP_S[m_sel];
      end else begin
        e_rd = 32'h0;
        e_ry = (m_err_left != 2);
        e_rs = (m_err_left != 0);
      end
      chk("rnd_hrdata", HRDATA, e_rd);
      chk("rnd_hready", 32'(HREADY), 32'(e_ry));
      chk("rnd_hresp", 32'(HRESP), 32'(e_rs));
      chk("rnd_err_cnt", 32'(ERR_CNT), 32'(m_cnt));
      chk("rnd_err_addr", ERR_ADDR, m_addr);
      $display("rnd %0d: htrans=%0d enc=%0d hrdata=%08h hready=%0b hresp=%0b err_cnt=%0d",
               c, HTRANS, HSEL_ENCODE, HRDATA, HREADY, HRESP, ERR_CNT);

      // Advance the model across the coming edge using the inputs now on the bus.
      if (e_ry) begin
        hit_c = (HSEL_A[10:0] != '0) && (int'(HSEL_ENCODE) < 11);
        m_hit = hit_c;
        m_sel = int'(HSEL_ENCODE);
        if (HTRANS[1] && !hit_c) begin
          m_err_left = 2;
          m_addr = HADDR;
          if (m_cnt < 255) m_cnt++;
        end else begin
          m_err_left = 0;
        end
      end else if (m_err_left == 2) begin
        m_err_left = 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
